// File: rtl/osc_trim_ctrl_if.sv
// Signal bundle between osc_trim_ctrl, the command sequencer, TMON and the oscillator trim input.
interface osc_trim_ctrl_if #(
  parameter int unsigned TRIM_W = 6
);
  logic              CAL_START;
  logic [15:0]       TARGET;
  logic              TSTOP;
  logic [15:0]       TVAL;
  logic              MON_RSTN;
  logic [TRIM_W-1:0] TRIM;
  logic [15:0]       CAL_TVAL;
  logic              CAL_BUSY;
  logic              CAL_DONE;
  logic              CAL_FAIL;

  modport master (
    output CAL_START, TARGET, TSTOP, TVAL,
    input  MON_RSTN, TRIM, CAL_TVAL, CAL_BUSY, CAL_DONE, CAL_FAIL
  );

  modport slave (
    input  CAL_START, TARGET, TSTOP, TVAL,
    output MON_RSTN, TRIM, CAL_TVAL, CAL_BUSY, CAL_DONE, CAL_FAIL
  );
endinterface

// File: rtl/osc_trim_ctrl.sv
// Successive-approximation oscillator trim calibration, MSB first, with a final verify window.
// Optional WAIT watchdog enabled by macro OSC_CAL_TIMEOUT_EN.
module osc_trim_ctrl #(
  parameter int unsigned       TRIM_W    = 6,
  parameter logic [TRIM_W-1:0] TRIM_INIT = '0,
  parameter int unsigned       TOL       = 8,
  parameter int unsigned       TIMEOUT   = 64
) (
  input logic            NCLKD,
  input logic            RSTN,
  osc_trim_ctrl_if.slave bus
);
  localparam int unsigned IDX_W  = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam int unsigned DIFF_W = 17;

  typedef enum logic [2:0] {
    S_IDLE, S_MRST, S_WAIT, S_EVAL, S_DONE, S_FAIL
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [TRIM_W-1:0]   r_trim, w_trim_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_verify, w_verify_nxt;
  logic                r_mrst_cnt, w_mrst_cnt_nxt;
  logic                r_mon_rstn, w_mon_rstn_nxt;
  logic [15:0]         r_cal_tval, w_cal_tval_nxt;
  logic                r_busy;
  logic                r_done, w_done_nxt;
  logic                r_fail, w_fail_nxt;
  logic                r_s1, r_s2, r_s3;
  logic                w_rise;
  logic                w_tmo_hit;
  logic [DIFF_W-1:0]   w_diff;

`ifdef OSC_CAL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts WAIT cycles; restarts every time WAIT is left.
  always_ff @(posedge NCLKD or negedge RSTN) begin
    if (!RSTN)                  r_tmo_cnt <= '0;
    else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    else                        r_tmo_cnt <= '0;
  end

  assign w_tmo_hit = (r_state == S_WAIT) && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_tmo_hit        = 1'b0;
`endif

  // TSTOP is asynchronous: two-flop sync plus edge flop, flushed on every monitor reset.
  always_ff @(posedge NCLKD or negedge RSTN) begin
    if (!RSTN) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else if (r_state == S_MRST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.TSTOP;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_diff = (bus.TVAL >= bus.TARGET) ? ({1'b0, bus.TVAL} - {1'b0, bus.TARGET})
                                           : ({1'b0, bus.TARGET} - {1'b0, bus.TVAL});

  always_ff @(posedge NCLKD or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= S_IDLE;
      r_trim     <= TRIM_INIT;
      r_idx      <= '0;
      r_verify   <= 1'b0;
      r_mrst_cnt <= 1'b0;
      r_mon_rstn <= 1'b0;
      r_cal_tval <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_trim     <= w_trim_nxt;
      r_idx      <= w_idx_nxt;
      r_verify   <= w_verify_nxt;
      r_mrst_cnt <= w_mrst_cnt_nxt;
      r_mon_rstn <= w_mon_rstn_nxt;
      r_cal_tval <= w_cal_tval_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
      r_fail     <= w_fail_nxt;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    w_state_nxt    = r_state;
    w_trim_nxt     = r_trim;
    w_idx_nxt      = r_idx;
    w_verify_nxt   = r_verify;
    w_mrst_cnt_nxt = 1'b0;
    w_mon_rstn_nxt = 1'b1;
    w_cal_tval_nxt = r_cal_tval;
    w_done_nxt     = 1'b0;
    w_fail_nxt     = r_fail;
    unique case (r_state)
      S_IDLE: begin
        if (bus.CAL_START) begin
          w_trim_nxt             = '0;
          w_trim_nxt[TRIM_W-1]   = 1'b1;
          w_idx_nxt              = IDX_W'(TRIM_W - 1);
          w_verify_nxt           = 1'b0;
          w_fail_nxt             = 1'b0;
          w_mon_rstn_nxt         = 1'b0;
          w_state_nxt            = S_MRST;
        end
      end
      S_MRST: begin
        if (r_mrst_cnt) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_mrst_cnt_nxt = 1'b1;
          w_mon_rstn_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (w_rise) begin
          w_state_nxt = S_EVAL;
        end else if (w_tmo_hit) begin
          w_fail_nxt  = 1'b1;
          w_state_nxt = S_FAIL;
        end
      end
      S_EVAL: begin
        w_cal_tval_nxt = bus.TVAL;
        if (r_verify) begin
          if (w_diff <= DIFF_W'(TOL)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_fail_nxt  = 1'b1;
            w_state_nxt = S_FAIL;
          end
        end else begin
          if (bus.TVAL > bus.TARGET) w_trim_nxt[r_idx] = 1'b0;
          if (r_idx != '0) begin
            w_trim_nxt[r_idx - IDX_W'(1)] = 1'b1;
            w_idx_nxt                     = r_idx - IDX_W'(1);
          end else begin
            w_verify_nxt = 1'b1;
          end
          w_mon_rstn_nxt = 1'b0;
          w_state_nxt    = S_MRST;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      S_FAIL: begin
        w_fail_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.MON_RSTN = r_mon_rstn;
  assign bus.TRIM     = r_trim;
  assign bus.CAL_TVAL = r_cal_tval;
  assign bus.CAL_BUSY = r_busy;
  assign bus.CAL_DONE = r_done;
  assign bus.CAL_FAIL = r_fail;
endmodule

// File: tb/tb_osc_trim_ctrl.sv
// Directed bench for osc_trim_ctrl with a TMON model whose count is TVAL = 100 + 10*TRIM.
module tb_osc_trim_ctrl;
  localparam int unsigned TRIM_W = 6;

  logic NCLKD = 1'b0;
  logic RSTN;
  int   n_tests = 0;
  int   n_fail  = 0;

  osc_trim_ctrl_if #(.TRIM_W(TRIM_W)) bus ();

  osc_trim_ctrl #(
    .TRIM_W(TRIM_W), .TRIM_INIT(6'd0), .TOL(8), .TIMEOUT(64)
  ) dut (
    .NCLKD(NCLKD),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 NCLKD = ~NCLKD;

  assign bus.TVAL = 16'(100 + 10 * int'(bus.TRIM));

  // TMON model: 0 = rise after 16 cycles, 1 = never rises, 2 = rise/fall/rise glitch
  int tmon_mode = 0;
  int win_cnt   = 0;
  always @(negedge NCLKD) begin
    if (!bus.MON_RSTN) begin
      win_cnt   = 0;
      bus.TSTOP = 1'b0;
    end else begin
      win_cnt++;
      if (tmon_mode == 0 && win_cnt == 16) bus.TSTOP = 1'b1;
      if (tmon_mode == 2) begin
        if (win_cnt == 16 || win_cnt == 18) bus.TSTOP = 1'b1;
        else if (win_cnt == 17)             bus.TSTOP = 1'b0;
      end
    end
  end

  // Observers: monitor-reset pulses (with the trim in use) and DONE pulses
  logic prev_mon = 1'b0;
  int   pulses   = 0;
  int   dones    = 0;
  int   trims[64];
  always @(negedge NCLKD) begin
    if (prev_mon && !bus.MON_RSTN) begin
      if (pulses < 64) trims[pulses] = int'(bus.TRIM);
      pulses++;
    end
    if (bus.CAL_DONE) dones++;
    prev_mon = bus.MON_RSTN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge NCLKD);
    #1;
  endtask

  task automatic start_cal();
    bus.CAL_START = 1'b1;
    tick(1);
    bus.CAL_START = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (bus.CAL_BUSY && c < budget) begin
      tick(1);
      c++;
    end
    if (bus.CAL_BUSY) chk("busy_timeout", 32'(bus.CAL_BUSY), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bp, bd, wc, c;
    int exp_tr[7] = '{32, 16, 24, 28, 30, 31, 30};

    RSTN          = 1'b0;
    bus.CAL_START = 1'b0;
    bus.TARGET    = 16'd400;
    tick(3);
    chk("rst_mon_rstn", 32'(bus.MON_RSTN), 32'd0);
    chk("rst_trim",     32'(bus.TRIM),     32'd0);
    chk("rst_cal_tval", 32'(bus.CAL_TVAL), 32'd0);
    chk("rst_busy",     32'(bus.CAL_BUSY), 32'd0);
    chk("rst_done",     32'(bus.CAL_DONE), 32'd0);
    chk("rst_fail",     32'(bus.CAL_FAIL), 32'd0);
    RSTN = 1'b1;
    tick(1);
    chk("idle_mon_rstn", 32'(bus.MON_RSTN), 32'd1);
    chk("idle_busy",     32'(bus.CAL_BUSY), 32'd0);

    // Nominal calibration to TARGET=400
    bp = pulses; bd = dones;
    start_cal();
    chk("start_busy", 32'(bus.CAL_BUSY), 32'd1);
    chk("start_trim", 32'(bus.TRIM),     32'd32);
    chk("start_mrst0", 32'(bus.MON_RSTN), 32'd0);
    tick(1);
    chk("start_mrst1", 32'(bus.MON_RSTN), 32'd0);
    tick(1);
    chk("start_mrst_release", 32'(bus.MON_RSTN), 32'd1);
    wait_idle(400);
    chk("nom_trim",     32'(bus.TRIM),     32'd30);
    chk("nom_pulses",   32'(pulses - bp),  32'd7);
    chk("nom_cal_tval", 32'(bus.CAL_TVAL), 32'd400);
    chk("nom_dones",    32'(dones - bd),   32'd1);
    chk("nom_fail",     32'(bus.CAL_FAIL), 32'd0);
    for (int i = 0; i < 7; i++)
      chk($sformatf("nom_trim_seq%0d", i), 32'(trims[bp + i]), 32'(exp_tr[i]));

    // Unreachable target: all bits cleared, verify fails
    bus.TARGET = 16'd50;
    bp = pulses; bd = dones;
    start_cal();
    wait_idle(400);
    chk("low_trim",     32'(bus.TRIM),     32'd0);
    chk("low_cal_tval", 32'(bus.CAL_TVAL), 32'd100);
    chk("low_fail",     32'(bus.CAL_FAIL), 32'd1);
    chk("low_dones",    32'(dones - bd),   32'd0);
    chk("low_pulses",   32'(pulses - bp),  32'd7);
    bus.TARGET = 16'd400;
    bd = dones;
    start_cal();
    chk("restart_fail_clr", 32'(bus.CAL_FAIL), 32'd0);
    wait_idle(400);
    chk("restart_trim",  32'(bus.TRIM),     32'd30);
    chk("restart_fail",  32'(bus.CAL_FAIL), 32'd0);
    chk("restart_dones", 32'(dones - bd),   32'd1);

    // TSTOP never rises
    tmon_mode = 1;
    bp = pulses; bd = dones;
    start_cal();
`ifdef OSC_CAL_TIMEOUT_EN
    wc = 0; c = 0;
    while (bus.CAL_BUSY && c < 300) begin
      tick(1);
      c++;
      if (bus.CAL_BUSY && bus.MON_RSTN && !bus.CAL_FAIL) wc++;
    end
    if (bus.CAL_BUSY) chk("tmo_busy_timeout", 32'(bus.CAL_BUSY), 32'd0);
    chk("tmo_wait_cycles", 32'(wc),           32'd64);
    chk("tmo_fail",        32'(bus.CAL_FAIL), 32'd1);
    chk("tmo_trim",        32'(bus.TRIM),     32'd32);
    chk("tmo_cal_tval",    32'(bus.CAL_TVAL), 32'd400);
    chk("tmo_dones",       32'(dones - bd),   32'd0);
    chk("tmo_pulses",      32'(pulses - bp),  32'd1);
`else
    tick(1000);
    chk("hang_busy",     32'(bus.CAL_BUSY), 32'd1);
    chk("hang_trim",     32'(bus.TRIM),     32'd32);
    chk("hang_mon_rstn", 32'(bus.MON_RSTN), 32'd1);
    chk("hang_fail",     32'(bus.CAL_FAIL), 32'd0);
    RSTN = 1'b0;
    #1;
    chk("hang_rst_busy", 32'(bus.CAL_BUSY), 32'd0);
    tick(1);
    RSTN = 1'b1;
    tick(2);
`endif
    tmon_mode = 0;

    // CAL_START during WAIT is ignored
    bp = pulses; bd = dones;
    start_cal();
    tick(5);
    start_cal();
    wait_idle(400);
    chk("ign_pulses", 32'(pulses - bp), 32'd7);
    chk("ign_trim",   32'(bus.TRIM),    32'd30);
    chk("ign_dones",  32'(dones - bd),  32'd1);

    // Glitchy TSTOP: only one evaluation per window
    tmon_mode = 2;
    bp = pulses; bd = dones;
    start_cal();
    wait_idle(400);
    chk("dbl_pulses",   32'(pulses - bp),  32'd7);
    chk("dbl_trim",     32'(bus.TRIM),     32'd30);
    chk("dbl_cal_tval", 32'(bus.CAL_TVAL), 32'd400);
    chk("dbl_dones",    32'(dones - bd),   32'd1);
    tmon_mode = 0;

    // Reset during the third measurement
    bp = pulses; bd = dones;
    start_cal();
    c = 0;
    while (!((pulses - bp) == 3 && bus.MON_RSTN) && c < 200) begin
      tick(1);
      c++;
    end
    if (c >= 200) chk("mid_reach_timeout", 32'(pulses - bp), 32'd3);
    tick(4);
    RSTN = 1'b0;
    #1;
    chk("mid_trim",     32'(bus.TRIM),     32'd0);
    chk("mid_busy",     32'(bus.CAL_BUSY), 32'd0);
    chk("mid_mon_rstn", 32'(bus.MON_RSTN), 32'd0);
    chk("mid_cal_tval", 32'(bus.CAL_TVAL), 32'd0);
    tick(2);
    chk("mid_hold_mon_rstn", 32'(bus.MON_RSTN), 32'd0);
    RSTN = 1'b1;
    tick(20);
    chk("mid_no_done", 32'(dones - bd),   32'd0);
    chk("mid_no_fail", 32'(bus.CAL_FAIL), 32'd0);
    chk("mid_idle",    32'(bus.CAL_BUSY), 32'd0);
    bd = dones;
    start_cal();
    wait_idle(400);
    chk("post_rst_trim",  32'(bus.TRIM),   32'd30);
    chk("post_rst_dones", 32'(dones - bd), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
